// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU with a registered result.
//
// Accepts one operation on a rising edge where valid_i && ready_o, then presents
// result_o / zero_o / overflow_o with valid_o until the consumer raises ready_i.
// Non-MUL operations complete in one cycle. When ALU_MULTICYCLE_MUL_EN is
// defined, MUL (1110) runs an iterative shift-add multiplier over WIDTH cycles.
// Without the macro, 1110 is an unsupported encoding (result 0, latency 1).
//
// Ports:
//   clk_i       clock, all state on rising edge
//   rst_i       asynchronous active-high reset
//   valid_i     operands and ctrl_i present
//   ready_o     block can accept an operation (IDLE)
//   src1_i      operand A
//   src2_i      operand B (shift amount = src2_i[SHAMT_W-1:0])
//   ctrl_i      operation select
//   valid_o     result outputs valid (DONE)
//   ready_i     consumer takes the result
//   result_o    registered result
//   zero_o      result_o == 0
//   overflow_o  registered signed overflow (ADD/SUB only)

module alu_multicycle #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSltu = 4'b1000;
  localparam logic [3:0] OpXor  = 4'b1001;
  localparam logic [3:0] OpSll  = 4'b1010;
  localparam logic [3:0] OpSrl  = 4'b1011;
  localparam logic [3:0] OpSra  = 4'b1100;
  localparam logic [3:0] OpNor  = 4'b1101;
`ifdef ALU_MULTICYCLE_MUL_EN
  localparam logic [3:0] OpMul  = 4'b1110;
`endif

`ifdef ALU_MULTICYCLE_MUL_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StDone} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;

  // --------------------------------------------------------------------------
  // Single-cycle operation datapath
  // --------------------------------------------------------------------------
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum, diff, sra_res;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               msb_a, msb_b;

  assign shamt   = src2_i[SHAMT_W-1:0];
  assign sum     = src1_i + src2_i;
  assign diff    = src1_i - src2_i;
  assign sra_res = $signed(src1_i) >>> shamt;
  assign msb_a   = src1_i[WIDTH-1];
  assign msb_b   = src2_i[WIDTH-1];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ctrl_i)
      OpAnd:  alu_res = src1_i & src2_i;
      OpOr:   alu_res = src1_i | src2_i;
      OpAdd: begin
        alu_res = sum;
        // Same-sign operands producing a result of the other sign.
        alu_ovf = (msb_a == msb_b) && (sum[WIDTH-1] != msb_a);
      end
      OpSub: begin
        alu_res = diff;
        // Different-sign operands where the result sign departs from src1.
        alu_ovf = (msb_a != msb_b) && (diff[WIDTH-1] != msb_a);
      end
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
      OpXor:  alu_res = src1_i ^ src2_i;
      OpNor:  alu_res = ~(src1_i | src2_i);
      OpSll:  alu_res = src1_i << shamt;
      OpSrl:  alu_res = src1_i >> shamt;
      OpSra:  alu_res = sra_res;
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

`ifdef ALU_MULTICYCLE_MUL_EN
  // --------------------------------------------------------------------------
  // Iterative shift-add multiplier state
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   acc_next;

  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    overflow_d = overflow_q;
`ifdef ALU_MULTICYCLE_MUL_EN
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    count_d    = count_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
`ifdef ALU_MULTICYCLE_MUL_EN
          if (ctrl_i == OpMul) begin
            state_d  = StBusy;
            mcand_d  = src1_i;
            mplier_d = src2_i;
            acc_d    = '0;
            count_d  = '0;
          end else begin
`endif
            state_d    = StDone;
            result_d   = alu_res;
            overflow_d = alu_ovf;
`ifdef ALU_MULTICYCLE_MUL_EN
          end
`endif
        end
      end
`ifdef ALU_MULTICYCLE_MUL_EN
      StBusy: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        // Counter wraps back to 0 on the last iteration since WIDTH is a power of two.
        count_d  = count_q + 1'b1;
        if (count_q == SHAMT_W'(WIDTH - 1)) begin
          state_d    = StDone;
          result_d   = acc_next;
          overflow_d = 1'b0;
        end
      end
`endif
      StDone: begin
        if (ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      result_q   <= '0;
      overflow_q <= 1'b0;
`ifdef ALU_MULTICYCLE_MUL_EN
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
`ifdef ALU_MULTICYCLE_MUL_EN
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
`endif
    end
  end

  // Handshake outputs come from registered state only.
  assign ready_o    = (state_q == StIdle);
  assign valid_o    = (state_q == StDone);
  assign result_o   = result_q;
  assign zero_o     = (result_q == '0);
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [3:0]  ctrl_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        overflow_o;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .ctrl_i     (ctrl_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

`ifdef ALU_MULTICYCLE_MUL_EN
  localparam int MulLat = 33;
  localparam logic [31:0] MulRes0 = 32'hFFFFFFFD;
  localparam logic [31:0] MulRes1 = 32'h00123400;
`else
  localparam int MulLat = 1;
  localparam logic [31:0] MulRes0 = 32'h0;
  localparam logic [31:0] MulRes1 = 32'h0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs[NVec];

  // Issue one operation from IDLE and wait (bounded) for valid_o.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output logic o,
                        output int lat, output logic rdy_low);
    @(negedge clk);
    chk("ready_o before accept", 32'(ready_o), 32'd1);
    ctrl_i  = c;
    src1_i  = a;
    src2_i  = b;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    src1_i  = 32'hDEADBEEF;
    src2_i  = 32'h00C0FFEE;
    ctrl_i  = 4'b0001;
    lat     = 0;
    rdy_low = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (ready_o) rdy_low = 1'b0;
    end while (!valid_o && lat < 100);
    r = result_o;
    z = zero_o;
    o = overflow_o;
  endtask

  task automatic release_result();
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic        z;
    logic        o;
    int          lat;
    logic        rdy_low;
    string       tag;

    vecs[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1};  // ADD ovf
    vecs[1]  = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1};  // SUB zero
    vecs[2]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1};  // SLT
    vecs[3]  = '{4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1};  // SLTU
    vecs[4]  = '{4'b1100, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1};  // SRA
    vecs[5]  = '{4'b1011, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1};  // SRL
    vecs[6]  = '{4'b1010, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1};  // SLL 31
    vecs[7]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1};  // AND
    vecs[8]  = '{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1};  // OR
    vecs[9]  = '{4'b1001, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1};  // XOR
    vecs[10] = '{4'b1101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1};  // NOR
    vecs[11] = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1};  // SUB ovf
    vecs[12] = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1};  // ADD wrap
    vecs[13] = '{4'b0011, 32'h12345678, 32'h11111111, 32'h00000000, 1'b0, 1};  // unsupported
    vecs[14] = '{4'b1010, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1};  // SLL upper ignored
    vecs[15] = '{4'b1110, 32'hFFFFFFFF, 32'h00000003, MulRes0, 1'b0, MulLat};   // MUL
    vecs[16] = '{4'b1110, 32'h00001234, 32'h00000100, MulRes1, 1'b0, MulLat};   // MUL

    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    src1_i  = '0;
    src2_i  = '0;
    ctrl_i  = '0;
    #12;
    chk("reset valid_o", 32'(valid_o), 32'd0);
    chk("reset ready_o", 32'(ready_o), 32'd1);
    chk("reset result_o", result_o, 32'd0);
    chk("reset zero_o", 32'(zero_o), 32'd1);
    chk("reset overflow_o", 32'(overflow_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    for (int i = 0; i < NVec; i++) begin
      run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, r, z, o, lat, rdy_low);
      tag = $sformatf("vec%0d", i);
      chk({tag, " result"}, r, vecs[i].res);
      chk({tag, " zero"}, 32'(z), 32'(vecs[i].res == 32'd0));
      chk({tag, " overflow"}, 32'(o), 32'(vecs[i].ovf));
      chk({tag, " latency"}, 32'(lat), 32'(vecs[i].lat));
      chk({tag, " ready_o low while pending"}, 32'(rdy_low), 32'd1);
      release_result();
    end

    // Backpressure: result held while ready_i stays low; operand churn ignored.
    run_op(4'b0010, 32'h00000011, 32'h00000022, r, z, o, lat, rdy_low);
    chk("bp result", r, 32'h00000033);
    for (int k = 0; k < 5; k++) begin
      src1_i  = 32'h0BADF00D + 32'(k);
      valid_i = 1'b1;
      @(negedge clk);
      chk("bp valid_o held", 32'(valid_o), 32'd1);
      chk("bp ready_o low", 32'(ready_o), 32'd0);
      chk("bp result stable", result_o, 32'h00000033);
    end
    valid_i = 1'b0;
    release_result();
    @(negedge clk);
    chk("bp valid_o after take", 32'(valid_o), 32'd0);
    chk("bp ready_o after take", 32'(ready_o), 32'd1);

    // Reset in the middle of an operation (MUL when built, else a held result).
    @(negedge clk);
`ifdef ALU_MULTICYCLE_MUL_EN
    ctrl_i = 4'b1110;
    src1_i = 32'd7;
    src2_i = 32'd9;
`else
    ctrl_i = 4'b0010;
    src1_i = 32'h10;
    src2_i = 32'h20;
`endif
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid-op ready_o low", 32'(ready_o), 32'd0);
    chk("mid-op result nonzero", 32'(result_o != 32'd0), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async reset valid_o", 32'(valid_o), 32'd0);
    chk("async reset ready_o", 32'(ready_o), 32'd1);
    chk("async reset result_o", result_o, 32'd0);
    chk("async reset zero_o", 32'(zero_o), 32'd1);
    @(negedge clk);
    rst_i = 1'b0;

    run_op(4'b0010, 32'd2, 32'd3, r, z, o, lat, rdy_low);
    chk("post-reset ADD result", r, 32'd5);
    chk("post-reset ADD latency", 32'(lat), 32'd1);
    chk("post-reset ADD overflow", 32'(o), 32'd0);
    release_result();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
